mem_sram_if: RTL and testbench

Bridges the pipeline's MEM-stage load/store requests onto the SRAM-like data bus (req/addr_ok/data_ok) that feeds the data memory. It aligns store data to byte lanes, issues requests, and tracks in-order outstanding transactions in a small FIFO so that back-to-back accesses continue while earlier ones await `data_data_ok`. It extracts and sign/zero-extends load results, and discards responses belonging to flushed instructions.

---
 rtl/mem_sram_if_pkg.sv | 47 ++++
 rtl/mem_sram_if_if.sv | 22 ++
 rtl/mem_req_fifo.sv | 55 +++++
 rtl/mem_sram_if.sv | 74 +++++++
 tb/tb_mem_sram_if.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_sram_if_pkg.sv
// Shared types and lane helpers for the MEM-stage to SRAM-bus bridge.
// Pure declarations and functions; no state, no latency, no backpressure.
// Store lanes are replicated; load lanes are selected, then extended.
package mem_if_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic       wr;
        logic [1:0] size;
        logic       sgn;
        logic [1:0] off;
        logic       drop;
    } mem_entry_t;

    function automatic logic [31:0] align_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SIZE_BYTE: align_wdata = {4{wdata[7:0]}};
            SIZE_HALF: align_wdata = {2{wdata[15:0]}};
            default:   align_wdata = wdata;
        endcase
    endfunction

    function automatic logic [31:0] extract_rdata(input mem_entry_t e, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (e.off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = e.off[1] ? rdata[31:16] : rdata[15:0];
        if (e.wr) begin
            extract_rdata = '0;
        end else begin
            case (e.size)
                SIZE_BYTE: extract_rdata = {{24{e.sgn & b[7]}}, b};
                SIZE_HALF: extract_rdata = {{16{e.sgn & h[15]}}, h};
                default:   extract_rdata = rdata;
            endcase
        end
    endfunction

endpackage

// File: rtl/mem_sram_if_if.sv
// SRAM-like data bus: req/addr_ok request phase, in-order data_ok response phase.
// Master is the bridge; slave is the data memory.
interface mem_sram_if_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_req_fifo.sv
// In-order tracker of outstanding bus transactions with broadcast drop marking.
// Head visible combinationally; push/pop take effect at the clock edge.
// Push is ignored when full unless a pop frees the slot in the same cycle.
module mem_req_fifo
    import mem_if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  mem_entry_t push_entry,
    input  logic       pop,
    input  logic       mark_drop,
    output mem_entry_t head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    mem_entry_t     ent [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = ent[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            // Marking every slot is safe: free slots are overwritten on push.
            if (mark_drop) begin
                for (int i = 0; i < DEPTH; i++) ent[i].drop <= 1'b1;
            end
            if (do_push) begin
                ent[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end
endmodule

// File: rtl/mem_sram_if.sv
// Bridges MEM-stage loads/stores onto the SRAM bus with in-order outstanding tracking.
// Request and response are combinational; response d cycles after accept for delay-d memory.
// Stalls mem_ready when the tracker is full, unless data_ok frees a slot in the same cycle.
module mem_sram_if
    import mem_if_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        flush,
    output logic        mem_ready,
    output logic        mem_misalign,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        protocol_err,
    mem_sram_if_if.master bus
);
    logic [1:0] size_n;
    logic       misalign_raw;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       accept;
    mem_entry_t head;
    mem_entry_t push_entry;

    assign size_n       = (mem_size == 2'b11) ? SIZE_WORD : mem_size;
    assign misalign_raw = ((size_n == SIZE_HALF) && mem_addr[0]) ||
                          ((size_n == SIZE_WORD) && (mem_addr[1:0] != 2'b00));
    assign mem_misalign = mem_valid && misalign_raw;

    // data_ok -> data_req path lets a full tracker still accept when a slot frees.
    assign pop          = bus.data_data_ok && !fifo_empty;
    assign bus.data_req = mem_valid && !misalign_raw && !flush && !rst && (!fifo_full || pop);
    assign bus.data_wr    = mem_wr;
    assign bus.data_size  = size_n;
    assign bus.data_addr  = mem_addr;
    assign bus.data_wdata = align_wdata(size_n, mem_wdata);

    assign accept    = bus.data_req && bus.data_addr_ok;
    assign mem_ready = accept || (mem_valid && misalign_raw && !rst);

    assign push_entry = '{wr: mem_wr, size: size_n, sgn: mem_signed, off: mem_addr[1:0], drop: 1'b0};

    assign resp_valid = pop && !head.drop && !rst;
    assign resp_rdata = (pop && !rst) ? extract_rdata(head, bus.data_rdata) : '0;

    mem_req_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (pop),
        .mark_drop  (flush),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            protocol_err <= 1'b0;
        end else if (bus.data_data_ok && fifo_empty) begin
            protocol_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_sram_if.sv
// Bench for mem_sram_if: fixed-delay memory model plus in-order response scoreboard.
module tb_mem_sram_if;
    import mem_if_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_wr = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        mem_signed = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        flush = 1'b0;
    wire         mem_ready, mem_misalign, resp_valid, protocol_err;
    wire  [31:0] resp_rdata;

    logic        model_ok = 1'b0;
    logic        inj = 1'b0;
    logic [31:0] model_rdata = '0;

    mem_sram_if_if bus ();
    assign bus.data_addr_ok = 1'b1;
    assign bus.data_data_ok = model_ok | inj;
    assign bus.data_rdata   = model_rdata;

    mem_sram_if #(.MAX_OUTSTANDING(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid    (mem_valid),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_signed   (mem_signed),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .flush        (flush),
        .mem_ready    (mem_ready),
        .mem_misalign (mem_misalign),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .protocol_err (protocol_err),
        .bus          (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int delay = 3;
    int n_resp = 0;
    logic [31:0] mem [0:255];

    typedef struct { logic vld; logic [31:0] data; } exp_t;
    typedef struct { int due; logic [31:0] word; } pend_t;
    exp_t  sb [$];
    pend_t pend [$];

    function automatic logic [31:0] ref_ext(input logic [1:0] sz, input logic sg,
                                            input logic [1:0] off, input logic [31:0] w);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (w >> (16 * off[1])) & 32'hFFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Downstream memory: answers in order, exactly `delay` cycles after accept.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            model_ok    = 1'b1;
            model_rdata = pend[0].word;
        end else begin
            model_ok    = 1'b0;
            model_rdata = 32'hDEAD_BEEF;
        end
    end

    // Scoreboard: pop/compare on data_ok, then apply flush, then record new accepts.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] w;
        int          idx;
        if (rst) begin
            sb.delete();
            pend.delete();
            checks++;
            if (resp_valid !== 1'b0 || bus.data_req !== 1'b0 || mem_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs resp_valid=%b data_req=%b mem_ready=%b expected all 0",
                         resp_valid, bus.data_req, mem_ready);
            end
        end else begin
            if (bus.data_data_ok && sb.size() > 0) begin
                if (pend.size() > 0) void'(pend.pop_front());
                e = sb.pop_front();
                n_resp++;
                checks++;
                if (resp_valid !== e.vld || (e.vld && resp_rdata !== e.data)) begin
                    errors++;
                    $display("FAIL sb_resp cyc=%0d got vld=%b data=%h expected vld=%b data=%h",
                             cyc, resp_valid, resp_rdata, e.vld, e.data);
                end
            end else begin
                if (pend.size() > 0 && bus.data_data_ok) void'(pend.pop_front());
                checks++;
                if (resp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL spurious_resp cyc=%0d got resp_valid=%b expected 0", cyc, resp_valid);
                end
            end
            if (flush) begin
                foreach (sb[i]) sb[i].vld = 1'b0;
            end
            if (bus.data_req && bus.data_addr_ok) begin
                idx = int'(bus.data_addr[9:2]);
                if (mem_wr) begin
                    if (bus.data_size == 2'b00)
                        mem[idx][8*bus.data_addr[1:0] +: 8] = bus.data_wdata[8*bus.data_addr[1:0] +: 8];
                    else if (bus.data_size == 2'b01)
                        mem[idx][16*bus.data_addr[1] +: 16] = bus.data_wdata[16*bus.data_addr[1] +: 16];
                    else
                        mem[idx] = bus.data_wdata;
                end
                w = mem[idx];
                e.vld  = 1'b1;
                e.data = mem_wr ? 32'h0 : ref_ext(mem_size == 2'b11 ? 2'b10 : mem_size,
                                                  mem_signed, mem_addr[1:0], w);
                sb.push_back(e);
                pend.push_back('{due: cyc + delay, word: w});
            end
        end
    end

    task automatic drive(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_wr = wr; mem_size = sz; mem_signed = sg;
        mem_addr = a; mem_wdata = wd;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        mem_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic wait_ready(input string name, output int acc, output int waited);
        acc = -1;
        waited = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            waited++;
        end
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL %s_ready_timeout got no mem_ready within 50 cycles expected accept", name);
        end
    endtask

    task automatic wait_resp(output int at);
        at = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int ok;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && pend.size() == 0) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (ok == 0) begin
            errors++;
            $display("FAIL %s_drain got %0d responses pending expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_valid = 1'b1; mem_addr = 32'h0; mem_size = 2'b10;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (protocol_err !== 1'b0 || dut.u_fifo.count !== 3'd0) begin
            errors++;
            $display("FAIL reset_state got perr=%b count=%0d expected 0 0", protocol_err, dut.u_fifo.count);
        end
    endtask

    task automatic test_load_byte();
        int acc, w, at;
        delay = 3;
        drive(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
        wait_ready("lb_signed", acc, w);
        idle();
        wait_resp(at);
        checks++;
        if (at - acc != 3 || resp_rdata !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_signed got lat=%0d data=%h expected lat=3 data=ffffff80", at - acc, resp_rdata);
        end
        drive(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        wait_ready("lbu", acc, w);
        idle();
        wait_resp(at);
        checks++;
        if (at - acc != 3 || resp_rdata !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu got lat=%0d data=%h expected lat=3 data=00000080", at - acc, resp_rdata);
        end
        wait_drain("load_byte");
    endtask

    task automatic test_store_half();
        int acc, w, at;
        delay = 3;
        drive(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_BEEF);
        @(negedge clk);
        checks++;
        if (bus.data_wdata !== 32'hBEEF_BEEF || bus.data_size !== 2'b01 || bus.data_wr !== 1'b1 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL sh_bus got wdata=%h size=%b wr=%b rdy=%b expected beefbeef 01 1 1",
                     bus.data_wdata, bus.data_size, bus.data_wr, mem_ready);
        end
        idle();
        wait_drain("store_half");
        drive(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
        wait_ready("lw_after_sh", acc, w);
        idle();
        wait_resp(at);
        checks++;
        if (at - acc != 3 || resp_rdata !== 32'hBEEF_3344) begin
            errors++;
            $display("FAIL lw_after_sh got lat=%0d data=%h expected lat=3 data=beef3344", at - acc, resp_rdata);
        end
        wait_drain("lw_after_sh");
    endtask

    task automatic test_back_to_back();
        int base;
        delay = 3;
        base = n_resp;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0);
            @(negedge clk);
            checks++;
            if (mem_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready i=%0d got mem_ready=%b expected 1", i, mem_ready);
            end
        end
        idle();
        wait_drain("b2b");
        checks++;
        if (n_resp - base != 8) begin
            errors++;
            $display("FAIL b2b_count got %0d responses expected 8", n_resp - base);
        end
    endtask

    task automatic test_stall();
        int base, acc, w, stalls;
        delay = 6;
        base = n_resp;
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0);
            wait_ready("stall", acc, w);
            stalls += w;
        end
        idle();
        wait_drain("stall");
        checks++;
        if (stalls == 0 || n_resp - base != 8) begin
            errors++;
            $display("FAIL stall got stalls=%0d responses=%0d expected stalls>0 responses=8", stalls, n_resp - base);
        end
    endtask

    task automatic test_flush();
        int seen;
        delay = 3;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0);
            @(negedge clk);
            checks++;
            if (mem_ready !== 1'b1) begin
                errors++;
                $display("FAIL flush_issue i=%0d got mem_ready=%b expected 1", i, mem_ready);
            end
        end
        drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.data_req !== 1'b0 || mem_ready !== 1'b0 || resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle got req=%b rdy=%b resp_valid=%b expected 0 0 1",
                     bus.data_req, mem_ready, resp_valid);
        end
        idle();
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_dropped got %0d valid responses expected 0", seen);
        end
        wait_drain("flush");
    endtask

    task automatic test_misalign();
        int seen;
        drive(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
        @(negedge clk);
        checks++;
        if (mem_misalign !== 1'b1 || mem_ready !== 1'b1 || bus.data_req !== 1'b0) begin
            errors++;
            $display("FAIL misalign_word got mis=%b rdy=%b req=%b expected 1 1 0",
                     mem_misalign, mem_ready, bus.data_req);
        end
        drive(1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
        @(negedge clk);
        checks++;
        if (mem_misalign !== 1'b1 || bus.data_req !== 1'b0) begin
            errors++;
            $display("FAIL misalign_half got mis=%b req=%b expected 1 0", mem_misalign, bus.data_req);
        end
        idle();
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL misalign_resp got %0d responses expected 0", seen);
        end
        drive(1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
        @(negedge clk);
        checks++;
        if (mem_misalign !== 1'b0 || bus.data_req !== 1'b1) begin
            errors++;
            $display("FAIL aligned_half got mis=%b req=%b expected 0 1", mem_misalign, bus.data_req);
        end
        idle();
        wait_drain("aligned_half");
    endtask

    task automatic test_protocol_err();
        int seen;
        @(posedge clk); #1 inj = 1'b1;
        @(posedge clk); #1 inj = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL perr_sticky got protocol_err=%b expected 1", protocol_err);
        end
        delay = 10;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        mem_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.u_fifo.count !== 3'd0 || protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got count=%0d perr=%b expected 0 0", dut.u_fifo.count, protocol_err);
        end
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_mid_resp got %0d responses expected 0", seen);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[8'h40] = 32'h80FF_1234;
        mem[8'h80] = 32'h1122_3344;
        test_reset();
        test_load_byte();
        test_store_half();
        test_back_to_back();
        test_stall();
        test_flush();
        test_misalign();
        test_protocol_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got simulation still running expected completion");
        $fatal(1, "watchdog");
    end
endmodule
